// File: rtl/ls_issue_unit_pkg.sv
// Shared definitions for the load/store issue unit: FSM state encoding,
// LS opcode constants and default datapath widths.
package ls_issue_unit_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int TAG_W_DEF  = 5;

    localparam logic OP_LOAD  = 1'b1;
    localparam logic OP_STORE = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_CDB  = 2'd2
    } ls_state_t;

    // Word alignment test on the two low address bits.
    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return |addr_lo;
    endfunction

endpackage

// File: rtl/ls_issue_unit.sv
// Load/store issue unit: pops one LS instruction from the issue queue,
// performs its data-memory access, and broadcasts load results on the CDB.
// One instruction in flight at a time (non-pipelined IDLE/MEM/CDB FSM).
module ls_issue_unit
    import ls_issue_unit_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int TAG_W     = TAG_W_DEF,
    parameter int CHK_ALIGN = 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    // issue queue side
    input  logic              IssueQue_Ready,
    input  logic [DATA_W-1:0] IssueQue_Data,
    input  logic [DATA_W-1:0] IssueQue_Address,
    input  logic [TAG_W-1:0]  IssueQue_Rd_Tag,
    input  logic              IssueQue_Opcode,
    output logic              Issueblk_Issue,
    // data memory side
    output logic              Mem_Req,
    output logic              Mem_We,
    output logic [DATA_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Mem_Wdata,
    input  logic              Mem_Ack,
    input  logic [DATA_W-1:0] Mem_Rdata,
    // CDB side
    output logic              Cdb_Req,
    input  logic              Cdb_Grant,
    output logic              CDB_Valid,
    output logic [TAG_W-1:0]  CDB_Tag,
    output logic [DATA_W-1:0] CDB_Data,
    // completion / status
    output logic              Store_Done,
    output logic              Align_Fault,
    input  logic              RB_Flush_Valid,
    output logic              Busy
);

    ls_state_t         state_reg, state_next;
    logic              op_reg, op_next;
    logic [TAG_W-1:0]  tag_reg, tag_next;
    logic [DATA_W-1:0] addr_reg, addr_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic [DATA_W-1:0] rdata_reg, rdata_next;
    logic              flushed_reg, flushed_next;
    logic              align_fault_reg, align_fault_next;

    logic              misaligned;
    logic              issue;
    logic              load_squashed;

    // Alignment check on the incoming address; compiled out when disabled.
    generate
        if (CHK_ALIGN != 0) begin : g_align_chk
            assign misaligned = is_misaligned(IssueQue_Address[1:0]);
        end else begin : g_no_align_chk
            assign misaligned = 1'b0;
        end
    endgenerate

    // A load is dropped if a flush was seen earlier in MEM or arrives with the ack.
    assign load_squashed = flushed_reg | RB_Flush_Valid;

    // State and latched-instruction registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_reg       <= ST_IDLE;
            op_reg          <= OP_STORE;
            tag_reg         <= '0;
            addr_reg        <= '0;
            data_reg        <= '0;
            rdata_reg       <= '0;
            flushed_reg     <= 1'b0;
            align_fault_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            op_reg          <= op_next;
            tag_reg         <= tag_next;
            addr_reg        <= addr_next;
            data_reg        <= data_next;
            rdata_reg       <= rdata_next;
            flushed_reg     <= flushed_next;
            align_fault_reg <= align_fault_next;
        end
    end

    // Next-state logic and issue handshake.
    always_comb begin
        state_next       = state_reg;
        op_next          = op_reg;
        tag_next         = tag_reg;
        addr_next        = addr_reg;
        data_next        = data_reg;
        rdata_next       = rdata_reg;
        flushed_next     = flushed_reg;
        align_fault_next = 1'b0;
        issue            = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                // The cycle that reports an alignment fault is the completing
                // cycle of that instruction, so no new issue is taken in it.
                // Reset is folded in so the handshake reads 0 while held in reset.
                issue = Rst_n & IssueQue_Ready & ~RB_Flush_Valid & ~align_fault_reg;
                if (issue) begin
                    op_next      = IssueQue_Opcode;
                    tag_next     = IssueQue_Rd_Tag;
                    addr_next    = IssueQue_Address;
                    data_next    = IssueQue_Data;
                    flushed_next = 1'b0;
                    if (misaligned) begin
                        align_fault_next = 1'b1;
                    end else begin
                        state_next = ST_MEM;
                    end
                end
            end

            ST_MEM: begin
                // The request is never withdrawn; a flush only marks a load dead.
                if (RB_Flush_Valid && op_reg == OP_LOAD) begin
                    flushed_next = 1'b1;
                end
                if (Mem_Ack) begin
                    if (op_reg == OP_STORE) begin
                        state_next = ST_IDLE;
                    end else begin
                        rdata_next = Mem_Rdata;
                        state_next = load_squashed ? ST_IDLE : ST_CDB;
                    end
                end
            end

            ST_CDB: begin
                // Either the broadcast happens or a flush abandons it.
                if (RB_Flush_Valid || Cdb_Grant) begin
                    state_next = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output decode from state and latched registers.
    always_comb begin
        Issueblk_Issue = issue;
        Mem_Req        = (state_reg == ST_MEM);
        Mem_We         = (state_reg == ST_MEM) && (op_reg == OP_STORE);
        Mem_Addr       = addr_reg;
        Mem_Wdata      = data_reg;
        Store_Done     = (state_reg == ST_MEM) && (op_reg == OP_STORE) && Mem_Ack;
        Cdb_Req        = (state_reg == ST_CDB);
        CDB_Valid      = (state_reg == ST_CDB) && Cdb_Grant && !RB_Flush_Valid;
        CDB_Tag        = tag_reg;
        CDB_Data       = rdata_reg;
        Align_Fault    = align_fault_reg;
        Busy           = (state_reg != ST_IDLE);
    end

endmodule

// File: tb/tb_ls_issue_unit.sv
// Directed bench for ls_issue_unit: table-driven transactions plus
// hand-written sequences for flush, fault back-pressure and async reset.
module tb_ls_issue_unit;

    logic        Clk;
    logic        Rst_n;
    logic        IssueQue_Ready;
    logic [31:0] IssueQue_Data;
    logic [31:0] IssueQue_Address;
    logic [4:0]  IssueQue_Rd_Tag;
    logic        IssueQue_Opcode;
    logic        Issueblk_Issue;
    logic        Mem_Req;
    logic        Mem_We;
    logic [31:0] Mem_Addr;
    logic [31:0] Mem_Wdata;
    logic        Mem_Ack;
    logic [31:0] Mem_Rdata;
    logic        Cdb_Req;
    logic        Cdb_Grant;
    logic        CDB_Valid;
    logic [4:0]  CDB_Tag;
    logic [31:0] CDB_Data;
    logic        Store_Done;
    logic        Align_Fault;
    logic        RB_Flush_Valid;
    logic        Busy;

    int total = 0;
    int bad   = 0;

    ls_issue_unit #(.DATA_W(32), .TAG_W(5), .CHK_ALIGN(1)) dut (
        .Clk              (Clk),
        .Rst_n            (Rst_n),
        .IssueQue_Ready   (IssueQue_Ready),
        .IssueQue_Data    (IssueQue_Data),
        .IssueQue_Address (IssueQue_Address),
        .IssueQue_Rd_Tag  (IssueQue_Rd_Tag),
        .IssueQue_Opcode  (IssueQue_Opcode),
        .Issueblk_Issue   (Issueblk_Issue),
        .Mem_Req          (Mem_Req),
        .Mem_We           (Mem_We),
        .Mem_Addr         (Mem_Addr),
        .Mem_Wdata        (Mem_Wdata),
        .Mem_Ack          (Mem_Ack),
        .Mem_Rdata        (Mem_Rdata),
        .Cdb_Req          (Cdb_Req),
        .Cdb_Grant        (Cdb_Grant),
        .CDB_Valid        (CDB_Valid),
        .CDB_Tag          (CDB_Tag),
        .CDB_Data         (CDB_Data),
        .Store_Done       (Store_Done),
        .Align_Fault      (Align_Fault),
        .RB_Flush_Valid   (RB_Flush_Valid),
        .Busy             (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic        op;
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  tag;
        int          ack_wait;    // Mem_Req cycles before the ack cycle
        int          grant_wait;  // Cdb_Req cycles before the grant cycle
        logic [31:0] rdata;
        int          exp_req_cycles;
        int          exp_cdb;
        int          exp_sd;
        int          exp_af;
        int          exp_done;    // completion cycle, issue cycle = 0
        logic [4:0]  exp_tag;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [31:0] all_outs();
        return {24'd0, Issueblk_Issue, Mem_Req, Mem_We, Cdb_Req, CDB_Valid,
                Store_Done, Align_Fault, Busy}
               | Mem_Addr | Mem_Wdata | CDB_Data | {27'd0, CDB_Tag};
    endfunction

    task automatic drive_issue(input logic op, input logic [31:0] addr,
                               input logic [31:0] data, input logic [4:0] tag);
        IssueQue_Ready   = 1'b1;
        IssueQue_Opcode  = op;
        IssueQue_Address = addr;
        IssueQue_Data    = data;
        IssueQue_Rd_Tag  = tag;
    endtask

    // Runs one instruction through a 12-cycle window with a scripted memory
    // and arbiter, then compares event counts, timing and payload.
    task automatic run_txn(input vec_t v, input int idx);
        int req_n = 0, grant_n = 0, cdb_n = 0, sd_n = 0, af_n = 0;
        int done_c = -1;
        logic [4:0]  ev_tag = '0;
        logic [31:0] ev_data = '0;
        tick();
        drive_issue(v.op, v.addr, v.data, v.tag);
        RB_Flush_Valid = 1'b0;
        #1;
        chk($sformatf("v%0d_issue", idx), {31'd0, Issueblk_Issue}, 32'd1);
        tick();
        IssueQue_Ready = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            Mem_Ack   = 1'b0;
            Mem_Rdata = 32'hA5A5_A5A5;
            Cdb_Grant = 1'b0;
            if (Mem_Req && req_n == v.ack_wait) begin
                Mem_Ack   = 1'b1;
                Mem_Rdata = v.rdata;
            end
            if (Cdb_Req && grant_n == v.grant_wait) Cdb_Grant = 1'b1;
            #1;
            if (Mem_Req) begin
                chk($sformatf("v%0d_maddr", idx), Mem_Addr, v.addr);
                chk($sformatf("v%0d_mwe", idx), {31'd0, Mem_We}, {31'd0, ~v.op});
                if (!v.op) chk($sformatf("v%0d_mwdata", idx), Mem_Wdata, v.data);
                req_n++;
            end
            if (Cdb_Req) grant_n++;
            if (CDB_Valid) begin
                cdb_n++; ev_tag = CDB_Tag; ev_data = CDB_Data; done_c = c;
            end
            if (Store_Done) begin
                sd_n++; done_c = c;
            end
            if (Align_Fault) begin
                af_n++; ev_tag = CDB_Tag; done_c = c;
            end
            tick();
        end
        Mem_Ack   = 1'b0;
        Cdb_Grant = 1'b0;
        chk($sformatf("v%0d_req_cycles", idx), req_n, v.exp_req_cycles);
        chk($sformatf("v%0d_cdb_count", idx), cdb_n, v.exp_cdb);
        chk($sformatf("v%0d_store_done", idx), sd_n, v.exp_sd);
        chk($sformatf("v%0d_align_fault", idx), af_n, v.exp_af);
        chk($sformatf("v%0d_done_cycle", idx), done_c, v.exp_done);
        if (v.exp_cdb != 0 || v.exp_af != 0)
            chk($sformatf("v%0d_tag", idx), {27'd0, ev_tag}, {27'd0, v.exp_tag});
        if (v.exp_cdb != 0)
            chk($sformatf("v%0d_data", idx), ev_data, v.exp_data);
        chk($sformatf("v%0d_busy_end", idx), {31'd0, Busy}, 32'd0);
        $display("txn %0d op=%0d addr=%h tag=%0d req=%0d cdb=%0d sd=%0d af=%0d done@%0d",
                 idx, v.op, v.addr, v.tag, req_n, cdb_n, sd_n, af_n, done_c);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //             op    addr          data          tag ackw grw rdata         req cdb sd af done tag  data
        vecs[0] = '{1'b1, 32'h0000_0100, 32'h0,        5'd7,  3, 0, 32'hDEAD_BEEF, 4, 1, 0, 0, 5, 5'd7,  32'hDEAD_BEEF};
        vecs[1] = '{1'b0, 32'h0000_0200, 32'h1234_5678, 5'd3, 2, 0, 32'h0,        3, 0, 1, 0, 3, 5'd3,  32'h0};
        vecs[2] = '{1'b1, 32'h0000_0102, 32'h0,        5'd9,  0, 0, 32'h0,        0, 0, 0, 1, 1, 5'd9,  32'h0};
        vecs[3] = '{1'b1, 32'h0000_0104, 32'h0,        5'd31, 0, 2, 32'h0BAD_F00D, 1, 1, 0, 0, 4, 5'd31, 32'h0BAD_F00D};
        vecs[4] = '{1'b0, 32'h0000_0203, 32'h7777_0000, 5'd4, 0, 0, 32'h0,        0, 0, 0, 1, 1, 5'd4,  32'h0};
        vecs[5] = '{1'b1, 32'h0000_03FC, 32'h0,        5'd0,  1, 1, 32'hFFFF_FFFF, 2, 1, 0, 0, 4, 5'd0,  32'hFFFF_FFFF};

        // Reset: outputs all zero even with a ready entry presented.
        Rst_n = 1'b0;
        IssueQue_Ready = 1'b1; IssueQue_Opcode = 1'b1;
        IssueQue_Address = 32'h10; IssueQue_Data = 32'h0; IssueQue_Rd_Tag = 5'd1;
        Mem_Ack = 1'b0; Mem_Rdata = 32'h0; Cdb_Grant = 1'b0; RB_Flush_Valid = 1'b0;
        repeat (2) @(posedge Clk);
        #2;
        chk("reset_outputs", all_outs(), 32'd0);
        IssueQue_Ready = 1'b0;
        Rst_n = 1'b1;

        // Flush in IDLE blocks the handshake.
        tick();
        drive_issue(1'b1, 32'h20, 32'h0, 5'd1);
        RB_Flush_Valid = 1'b1;
        #1;
        chk("idle_flush_no_issue", {31'd0, Issueblk_Issue}, 32'd0);
        IssueQue_Ready = 1'b0;
        RB_Flush_Valid = 1'b0;

        for (int i = 0; i < 6; i++) run_txn(vecs[i], i);

        // Flush one cycle after a load issues, ack two cycles later.
        tick();
        drive_issue(1'b1, 32'h80, 32'h0, 5'd5);
        #1;
        chk("fm_issue", {31'd0, Issueblk_Issue}, 32'd1);
        tick();
        IssueQue_Ready = 1'b0;
        RB_Flush_Valid = 1'b1;
        #1;
        chk("fm_req_held_on_flush", {31'd0, Mem_Req}, 32'd1);
        tick();
        RB_Flush_Valid = 1'b0;
        #1;
        chk("fm_req_still", {31'd0, Mem_Req}, 32'd1);
        tick();
        Mem_Ack = 1'b1; Mem_Rdata = 32'hCAFE_0001; Cdb_Grant = 1'b1;
        #1;
        chk("fm_no_cdb_ack", {31'd0, CDB_Valid}, 32'd0);
        tick();
        Mem_Ack = 1'b0;
        #1;
        chk("fm_busy_fell", {31'd0, Busy}, 32'd0);
        chk("fm_no_cdb_after", {30'd0, Cdb_Req, CDB_Valid}, 32'd0);
        Cdb_Grant = 1'b0;
        $display("txn flush_mem tag=5 dropped");
        run_txn(vecs[0], 10);

        // Flush while waiting for the CDB grant, with grant raised in the same cycle.
        tick();
        drive_issue(1'b1, 32'h84, 32'h0, 5'd6);
        #1;
        chk("fc_issue", {31'd0, Issueblk_Issue}, 32'd1);
        tick();
        IssueQue_Ready = 1'b0;
        Mem_Ack = 1'b1; Mem_Rdata = 32'h0000_6666;
        #1;
        chk("fc_mem_req", {31'd0, Mem_Req}, 32'd1);
        tick();
        Mem_Ack = 1'b0;
        #1;
        chk("fc_cdb_req", {31'd0, Cdb_Req}, 32'd1);
        chk("fc_no_valid_wo_grant", {31'd0, CDB_Valid}, 32'd0);
        tick();
        RB_Flush_Valid = 1'b1; Cdb_Grant = 1'b1;
        #1;
        chk("fc_valid_masked", {31'd0, CDB_Valid}, 32'd0);
        tick();
        RB_Flush_Valid = 1'b0;
        #1;
        chk("fc_late_grant_no_valid", {31'd0, CDB_Valid}, 32'd0);
        chk("fc_idle", {30'd0, Busy, Cdb_Req}, 32'd0);
        Cdb_Grant = 1'b0;
        $display("txn flush_cdb tag=6 dropped");

        // Fault cycle completes the faulting op; next issue one cycle later.
        tick();
        drive_issue(1'b1, 32'h101, 32'h0, 5'd12);
        #1;
        chk("af_issue", {31'd0, Issueblk_Issue}, 32'd1);
        tick();
        drive_issue(1'b1, 32'h108, 32'h0, 5'd13);
        #1;
        chk("af_pulse", {31'd0, Align_Fault}, 32'd1);
        chk("af_tag", {27'd0, CDB_Tag}, 32'd12);
        chk("af_blocks_issue", {31'd0, Issueblk_Issue}, 32'd0);
        chk("af_no_mem_req", {31'd0, Mem_Req}, 32'd0);
        tick();
        #1;
        chk("af_next_issue", {31'd0, Issueblk_Issue}, 32'd1);
        chk("af_pulse_once", {31'd0, Align_Fault}, 32'd0);
        tick();
        IssueQue_Ready = 1'b0;
        Mem_Ack = 1'b1; Mem_Rdata = 32'h0000_0055;
        #1;
        chk("af_follow_req", {31'd0, Mem_Req}, 32'd1);
        tick();
        Mem_Ack = 1'b0; Cdb_Grant = 1'b1;
        #1;
        chk("af_follow_valid", {31'd0, CDB_Valid}, 32'd1);
        chk("af_follow_tag", {27'd0, CDB_Tag}, 32'd13);
        chk("af_follow_data", CDB_Data, 32'h0000_0055);
        tick();
        Cdb_Grant = 1'b0;
        $display("txn fault_then_load tags=12,13");

        // Asynchronous reset in the middle of a memory access.
        tick();
        drive_issue(1'b0, 32'h40, 32'h9999_0000, 5'd2);
        #1;
        chk("rst_issue", {31'd0, Issueblk_Issue}, 32'd1);
        tick();
        IssueQue_Ready = 1'b0;
        #1;
        chk("rst_mem_req_before", {31'd0, Mem_Req}, 32'd1);
        Rst_n = 1'b0;
        #1;
        chk("rst_async_outputs", all_outs(), 32'd0);
        tick();
        Rst_n = 1'b1;
        #1;
        chk("rst_idle_after", {30'd0, Busy, Mem_Req}, 32'd0);
        $display("txn reset_mid_mem");
        run_txn(vecs[1], 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
